// File: rtl/fact_seq_unit.sv
// rtl/fact_seq_unit.sv - iterative factorial / falling-factorial engine
//
// Purpose:
//   Computes n! (mode 0) or the falling factorial n*(n-1)*...*(n-k+1)
//   (mode 1) with one multiply per RUN cycle.
//   The product is kept at RW bits.
//   A sticky flag records whether any partial product needed more than RW bits.
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst      in   1   asynchronous active-low reset
//   start    in   1   request pulse, honoured only in IDLE or DONE
//   mode     in   1   0 = n!, 1 = falling factorial over k terms
//   n        in   W   operand
//   k        in   W   term count (mode 1)
//   busy     out  1   high while iterating (RUN)
//   done     out  1   one-cycle pulse when result/ovf become final
//   result   out  RW  low RW bits of the product, held until the next start
//   ovf      out  1   sticky overflow for the current operation
//   cnt_out  out  W   current multiplicand
//   last     out  1   high in the RUN cycle applying the final multiplicand

module fact_seq_unit #(
  parameter int W  = 9,
  parameter int RW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [W-1:0]  n,
  input  logic [W-1:0]  k,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] result,
  output logic          ovf,
  output logic [W-1:0]  cnt_out,
  output logic          last
);

  localparam int PW = W + RW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [RW-1:0] result_q, result_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  terms_q, terms_d;
  logic          mode_q, mode_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          last_q, last_d;

  // Full-width product.
  // The bits above RW feed the overflow flag and are not kept.
  logic [PW-1:0] prod;
  logic [W-1:0]  cnt_dec;
  logic [W-1:0]  terms_dec;

  assign prod      = PW'(acc_q) * PW'(cnt_q);
  assign cnt_dec   = cnt_q - 1'b1;
  assign terms_dec = terms_q - 1'b1;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    terms_d  = terms_q;
    mode_d   = mode_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    last_d   = last_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        busy_d = 1'b0;
        last_d = 1'b0;
        if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
        if (start) begin
          acc_d  = RW'(1);
          ovf_d  = 1'b0;
          mode_d = mode;
          if (!mode) begin
            // 0! is handled as a single multiply by 1.
            cnt_d   = (n == '0) ? W'(1) : n;
            terms_d = k;
            busy_d  = 1'b1;
            last_d  = (n <= W'(1));
            state_d = S_RUN;
          end else if (k == '0) begin
            // Empty product: finish without iterating.
            cnt_d    = '0;
            terms_d  = '0;
            result_d = RW'(1);
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            cnt_d   = n;
            terms_d = k;
            busy_d  = 1'b1;
            last_d  = (k == W'(1)) || (n == '0);
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        acc_d    = prod[RW-1:0];
        result_d = prod[RW-1:0];
        ovf_d    = ovf_q | (|prod[PW-1:RW]);
        terms_d  = terms_dec;
        if (last_q) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          last_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_dec;
          // last is registered, so it is judged on the values the next cycle will use.
          // In mode 1 a zero multiplicand ends the run because the product is 0 from then on.
          if (mode_q) begin
            last_d = (terms_dec == W'(1)) || (cnt_dec == '0);
          end else begin
            last_d = (cnt_dec == W'(1));
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      acc_q    <= RW'(1);
      result_q <= '0;
      cnt_q    <= '0;
      terms_q  <= '0;
      mode_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      terms_q  <= terms_d;
      mode_q   <= mode_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      last_q   <= last_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign ovf     = ovf_q;
  assign cnt_out = cnt_q;
  assign last    = last_q;

endmodule

// File: tb/tb_fact_seq_unit.sv
// tb/tb_fact_seq_unit.sv - directed self-checking bench for fact_seq_unit

module tb_fact_seq_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mode;
  logic [8:0]  n;
  logic [8:0]  k;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        ovf;
  logic [8:0]  cnt_out;
  logic        last;

  int checks = 0;
  int errors = 0;

  fact_seq_unit #(.W(9), .RW(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .n       (n),
    .k       (k),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .ovf     (ovf),
    .cnt_out (cnt_out),
    .last    (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic m, input logic [8:0] nv,
                        input logic [8:0] kv, input int exp_cyc,
                        input logic [31:0] exp_res, input logic exp_ovf);
    int cyc;
    int lastc;
    int t;
    start = 1'b1; mode = m; n = nv; k = kv;
    step();
    start = 1'b0;
    chk({tag, "_ovf_clr"}, 64'(ovf), 64'(0));
    cyc = 0; lastc = 0; t = 0;
    while (done !== 1'b1 && t < 600) begin
      if (busy === 1'b1) cyc++;
      if (last === 1'b1) lastc++;
      step();
      t++;
    end
    chk({tag, "_done_seen"}, 64'(done), 64'(1));
    chk({tag, "_run_cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_last_cycles"}, 64'(lastc), 64'((exp_cyc > 0) ? 1 : 0));
    chk({tag, "_result"}, 64'(result), 64'(exp_res));
    chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
    chk({tag, "_cnt_done"}, 64'(cnt_out), 64'(0));
    chk({tag, "_busy_done"}, 64'(busy), 64'(0));
    step();
    chk({tag, "_done_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    int cyc;
    int t;
    rst = 1'b0; start = 1'b0; mode = 1'b0; n = '0; k = '0;
    #3;
    chk("rst_busy",   64'(busy),    64'(0));
    chk("rst_done",   64'(done),    64'(0));
    chk("rst_result", 64'(result),  64'(0));
    chk("rst_cnt",    64'(cnt_out), 64'(0));
    step();
    rst = 1'b1;
    step();
    chk("idle_busy", 64'(busy), 64'(0));

    // Mode 0, n=3: watch the down-counter and last cycle by cycle.
    start = 1'b1; mode = 1'b0; n = 9'd3;
    step();
    start = 1'b0;
    chk("n3_busy1", 64'(busy),    64'(1));
    chk("n3_cnt1",  64'(cnt_out), 64'(3));
    chk("n3_last1", 64'(last),    64'(0));
    step();
    chk("n3_cnt2",  64'(cnt_out), 64'(2));
    chk("n3_last2", 64'(last),    64'(0));
    step();
    chk("n3_cnt3",  64'(cnt_out), 64'(1));
    chk("n3_last3", 64'(last),    64'(1));
    step();
    chk("n3_done",   64'(done),    64'(1));
    chk("n3_busy",   64'(busy),    64'(0));
    chk("n3_result", 64'(result),  64'(6));
    chk("n3_ovf",    64'(ovf),     64'(0));
    chk("n3_cnt0",   64'(cnt_out), 64'(0));
    chk("n3_lastd",  64'(last),    64'(0));
    // Start during the DONE cycle, n=0.
    start = 1'b1; n = 9'd0;
    step();
    start = 1'b0;
    chk("n0_done_drop", 64'(done),    64'(0));
    chk("n0_busy",      64'(busy),    64'(1));
    chk("n0_cnt",       64'(cnt_out), 64'(1));
    chk("n0_last",      64'(last),    64'(1));
    step();
    chk("n0_done",   64'(done),   64'(1));
    chk("n0_result", 64'(result), 64'(1));
    chk("n0_ovf",    64'(ovf),    64'(0));
    step();
    chk("n0_idle", 64'(done), 64'(0));

    run_op("n1",  1'b0, 9'd1,  9'd0, 1,  32'd1,          1'b0);
    run_op("n12", 1'b0, 9'd12, 9'd0, 12, 32'd479001600,  1'b0);
    run_op("n13", 1'b0, 9'd13, 9'd0, 13, 32'd1932053504, 1'b1);
    run_op("n2",  1'b0, 9'd2,  9'd0, 2,  32'd2,          1'b0);

    run_op("f5k2",  1'b1, 9'd5,  9'd2,  2,  32'd20, 1'b0);
    run_op("f5k0",  1'b1, 9'd5,  9'd0,  0,  32'd1,  1'b0);
    run_op("f5k7",  1'b1, 9'd5,  9'd7,  6,  32'd0,  1'b0);
    run_op("f13k20", 1'b1, 9'd13, 9'd20, 14, 32'd0, 1'b1);
    run_op("f9k3",  1'b1, 9'd9,  9'd3,  3,  32'd504, 1'b0);

    // Start while running must be ignored.
    start = 1'b1; mode = 1'b0; n = 9'd6;
    step();
    start = 1'b0;
    chk("mid_cnt1", 64'(cnt_out), 64'(6));
    step();
    chk("mid_cnt2", 64'(cnt_out), 64'(5));
    start = 1'b1; n = 9'd2; mode = 1'b1; k = 9'd1;
    step();
    start = 1'b0;
    chk("mid_cnt3", 64'(cnt_out), 64'(4));
    chk("mid_busy", 64'(busy),    64'(1));
    cyc = 3; t = 0;
    while (done !== 1'b1 && t < 100) begin
      step();
      t++;
      if (busy === 1'b1) cyc++;
    end
    chk("mid_done_seen", 64'(done),   64'(1));
    chk("mid_cycles",    64'(cyc),    64'(6));
    chk("mid_result",    64'(result), 64'(720));
    step();

    // Asynchronous reset in RUN cycle 3.
    start = 1'b1; mode = 1'b0; n = 9'd6;
    step();
    start = 1'b0;
    step();
    step();
    chk("rr_cnt3", 64'(cnt_out), 64'(4));
    #2;
    rst = 1'b0;
    #1;
    chk("rr_busy",   64'(busy),    64'(0));
    chk("rr_done",   64'(done),    64'(0));
    chk("rr_result", 64'(result),  64'(0));
    chk("rr_ovf",    64'(ovf),     64'(0));
    chk("rr_cnt",    64'(cnt_out), 64'(0));
    chk("rr_last",   64'(last),    64'(0));
    step();
    step();
    rst = 1'b1;
    step();
    step();
    step();
    chk("rr_idle_busy", 64'(busy),    64'(0));
    chk("rr_idle_done", 64'(done),    64'(0));
    chk("rr_idle_cnt",  64'(cnt_out), 64'(0));
    run_op("n4", 1'b0, 9'd4, 9'd0, 4, 32'd24, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
